// File: rtl/alu_pkg.sv
// Shared constants for the flag-producing ALU and its sequencing front end:
// opcodes, status bit positions, condition codes and controller states.
package alu_pkg;

    localparam logic [3:0] OP_NOT   = 4'b0000;
    localparam logic [3:0] OP_NAND  = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_OR    = 4'b0111;
    localparam logic [3:0] OP_RIGHT = 4'b1000;
    localparam logic [3:0] OP_ARTH  = 4'b1001;
    localparam logic [3:0] OP_XNOR  = 4'b1100;
    localparam logic [3:0] OP_INC   = 4'b1101;
    localparam logic [3:0] OP_DEC   = 4'b1110;
    localparam logic [3:0] OP_LEFT  = 4'b1111;

    localparam int unsigned ST_C = 3;
    localparam int unsigned ST_V = 2;
    localparam int unsigned ST_Z = 1;
    localparam int unsigned ST_N = 0;

    typedef enum logic [2:0] {
        CC_AL = 3'b000,
        CC_EQ = 3'b001,
        CC_NE = 3'b010,
        CC_CS = 3'b011,
        CC_CC = 3'b100,
        CC_MI = 3'b101,
        CC_PL = 3'b110,
        CC_VS = 3'b111
    } cond_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_RESP  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational condition-code evaluation against the stored {C,V,Z,N} status.
module alu_cond_eval
    import alu_pkg::*;
(
    input  logic [3:0] status,
    input  logic [2:0] cond,
    output logic       take
);

    always_comb begin
        take = 1'b0;
        case (cond_t'(cond))
            CC_AL: take = 1'b1;
            CC_EQ: take = status[ST_Z];
            CC_NE: take = !status[ST_Z];
            CC_CS: take = status[ST_C];
            CC_CC: take = !status[ST_C];
            CC_MI: take = status[ST_N];
            CC_PL: take = !status[ST_N];
            CC_VS: take = status[ST_V];
        endcase
    end

endmodule

// File: rtl/alu_flag_ctrl.sv
// Command sequencer for the 8-bit flag-producing ALU: accumulator, status register,
// conditional execution. Define ALU_FLAG_CTRL_STICKY_V_EN to make the V status bit sticky.
module alu_flag_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic        cmd_src,
    input  logic [7:0]  cmd_imm,
    input  logic [2:0]  cmd_cond,
    input  logic        cmd_wb,
    input  logic        flg_clr,
    output logic [7:0]  alu_op1,
    output logic [7:0]  alu_op2,
    output logic [3:0]  alu_opcode,
    output logic        alu_en,
    input  logic [15:0] alu_result,
    input  logic [3:0]  alu_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_status,
    output logic        rsp_skipped,
    output logic [7:0]  acc
);

    state_t     state;
    logic [3:0] status;
    logic [3:0] status_d;
    logic [3:0] capture;
    logic       wb_q;
    logic       take;
    logic       accept;

    alu_cond_eval u_cond (
        .status (status),
        .cond   (cmd_cond),
        .take   (take)
    );

    assign accept = cmd_valid && cmd_ready;

    // Next status value; flg_clr overrides a coincident ISSUE capture.
    always_comb begin
`ifdef ALU_FLAG_CTRL_STICKY_V_EN
        capture = {alu_status[ST_C], status[ST_V] | alu_status[ST_V],
                   alu_status[ST_Z], alu_status[ST_N]};
`else
        capture = alu_status;
`endif
        status_d = status;
        if (state == S_ISSUE) status_d = capture;
        if (flg_clr)          status_d = '0;
    end

    // ALU drive is registered at accept so it is valid for exactly the ISSUE cycle;
    // acc cannot change between accept and ISSUE, so sampling it early is equivalent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            status      <= '0;
            acc         <= '0;
            wb_q        <= 1'b0;
            cmd_ready   <= 1'b0;
            alu_en      <= 1'b0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_opcode  <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_status  <= '0;
            rsp_skipped <= 1'b0;
        end else begin
            status <= status_d;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        wb_q      <= cmd_wb;
                        if (take) begin
                            state      <= S_ISSUE;
                            alu_en     <= 1'b1;
                            alu_opcode <= cmd_op;
                            alu_op1    <= cmd_src ? cmd_imm : acc;
                            alu_op2    <= cmd_src ? acc : cmd_imm;
                        end else begin
                            state       <= S_RESP;
                            rsp_valid   <= 1'b1;
                            rsp_skipped <= 1'b1;
                            rsp_result  <= '0;
                            rsp_status  <= status_d;
                        end
                    end
                end
                S_ISSUE: begin
                    alu_en      <= 1'b0;
                    alu_opcode  <= '0;
                    alu_op1     <= '0;
                    alu_op2     <= '0;
                    rsp_valid   <= 1'b1;
                    rsp_skipped <= 1'b0;
                    rsp_result  <= alu_result;
                    rsp_status  <= status_d;
                    if (wb_q) acc <= alu_result[7:0];
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    alu_en    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_ctrl.sv
// Directed bench for alu_flag_ctrl with a small behavioural ALU hooked to its ports.
// Honours ALU_FLAG_CTRL_STICKY_V_EN for the sticky-V expectations.
module tb_alu_flag_ctrl;
    import alu_pkg::*;

`ifdef ALU_FLAG_CTRL_STICKY_V_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = '0;
    logic        cmd_src = 1'b0;
    logic [7:0]  cmd_imm = '0;
    logic [2:0]  cmd_cond = '0;
    logic        cmd_wb = 1'b0;
    logic        flg_clr = 1'b0;
    logic [7:0]  alu_op1, alu_op2;
    logic [3:0]  alu_opcode;
    logic        alu_en;
    logic [15:0] alu_result;
    logic [3:0]  alu_status;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_status;
    logic        rsp_skipped;
    logic [7:0]  acc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_flag_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_imm(cmd_imm), .cmd_cond(cmd_cond), .cmd_wb(cmd_wb),
        .flg_clr(flg_clr),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode), .alu_en(alu_en),
        .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_status(rsp_status), .rsp_skipped(rsp_skipped), .acc(acc)
    );

    // Behavioural ALU subset: status is {C,V,Z,N}; C on SUB is borrow.
    always_comb begin
        logic [8:0]  s9;
        logic [15:0] r16;
        s9  = '0;
        r16 = '0;
        alu_status = '0;
        case (alu_opcode)
            OP_ADD: begin
                s9  = {1'b0, alu_op1} + {1'b0, alu_op2};
                r16 = {8'h00, s9[7:0]};
                alu_status = {s9[8], (alu_op1[7] == alu_op2[7]) && (s9[7] != alu_op1[7]),
                              s9[7:0] == 8'h00, s9[7]};
            end
            OP_SUB: begin
                s9  = {1'b0, alu_op1} - {1'b0, alu_op2};
                r16 = {8'h00, s9[7:0]};
                alu_status = {s9[8], (alu_op1[7] != alu_op2[7]) && (s9[7] != alu_op1[7]),
                              s9[7:0] == 8'h00, s9[7]};
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (alu_opcode == OP_AND)     r16 = {8'h00, alu_op1 & alu_op2};
                else if (alu_opcode == OP_OR) r16 = {8'h00, alu_op1 | alu_op2};
                else                          r16 = {8'h00, alu_op1 ^ alu_op2};
                alu_status = {1'b0, 1'b0, r16 == 16'h0, r16[7]};
            end
            OP_LEFT: begin
                r16 = {7'b0, alu_op1, 1'b0};
                alu_status = {alu_op1[7], 1'b0, r16 == 16'h0, r16[7]};
            end
            default: ;
        endcase
        alu_result = r16;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic        src;
        logic [7:0]  imm;
        logic [2:0]  cond;
        logic        wb;
        logic        clr;
        int          hold;
        logic [15:0] res;
        logic [3:0]  st;
        logic        skip;
        logic [7:0]  accv;
    } vec_t;

    // Sampling/driving happens 1 time unit after each rising edge.
    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int lat;
        int en_cnt;
        cmd_op = v.op; cmd_src = v.src; cmd_imm = v.imm; cmd_cond = v.cond; cmd_wb = v.wb;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "/cmd_ready"}, {31'b0, cmd_ready}, 1);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        flg_clr = v.clr;
        lat = 1;
        en_cnt = 0;
        while (!rsp_valid && lat < 10) begin
            if (alu_en) en_cnt++;
            @(posedge clk); #1;
            flg_clr = 1'b0;
            lat++;
        end
        flg_clr = 1'b0;
        chk({tag, "/latency"}, lat, v.skip ? 1 : 2);
        chk({tag, "/alu_en_cycles"}, en_cnt, v.skip ? 0 : 1);
        chk({tag, "/rsp_result"}, {16'b0, rsp_result}, {16'b0, v.res});
        chk({tag, "/rsp_status"}, {28'b0, rsp_status}, {28'b0, v.st});
        chk({tag, "/rsp_skipped"}, {31'b0, rsp_skipped}, {31'b0, v.skip});
        chk({tag, "/acc"}, {24'b0, acc}, {24'b0, v.accv});
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, {31'b0, rsp_valid}, 1);
            chk({tag, "/hold_ready"}, {31'b0, cmd_ready}, 0);
            chk({tag, "/hold_result"}, {16'b0, rsp_result}, {16'b0, v.res});
            chk({tag, "/hold_status"}, {28'b0, rsp_status}, {28'b0, v.st});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "/valid_drop"}, {31'b0, rsp_valid}, 0);
        chk({tag, "/ready_after"}, {31'b0, cmd_ready}, 1);
        chk({tag, "/alu_idle"}, {11'b0, alu_en, alu_op1, alu_op2, alu_opcode}, 0);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic src, input logic [7:0] imm,
                                input logic [2:0] cond, input logic wb, input logic clr,
                                input int hold, input logic [15:0] res, input logic [3:0] st,
                                input logic skip, input logic [7:0] accv);
        vec_t v;
        v.op = op; v.src = src; v.imm = imm; v.cond = cond; v.wb = wb; v.clr = clr;
        v.hold = hold; v.res = res; v.st = st; v.skip = skip; v.accv = accv;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[13];
        tbl[0]  = mk(OP_ADD,  1'b0, 8'h7F, CC_AL, 1'b1, 1'b0, 0, 16'h007F, 4'b0000, 1'b0, 8'h7F);
        tbl[1]  = mk(OP_ADD,  1'b0, 8'h81, CC_AL, 1'b0, 1'b0, 0, 16'h0000, 4'b1010, 1'b0, 8'h7F);
        tbl[2]  = mk(OP_SUB,  1'b0, 8'h7F, CC_EQ, 1'b1, 1'b0, 0, 16'h0000, 4'b0010, 1'b0, 8'h00);
        tbl[3]  = mk(OP_SUB,  1'b0, 8'h01, CC_AL, 1'b0, 1'b0, 5, 16'h00FF, 4'b1001, 1'b0, 8'h00);
        tbl[4]  = mk(OP_ADD,  1'b0, 8'h55, CC_EQ, 1'b1, 1'b0, 0, 16'h0000, 4'b1001, 1'b1, 8'h00);
        tbl[5]  = mk(OP_ADD,  1'b1, 8'hC1, CC_NE, 1'b1, 1'b0, 0, 16'h00C1, 4'b0001, 1'b0, 8'hC1);
        tbl[6]  = mk(OP_ADD,  1'b0, 8'h01, CC_CS, 1'b1, 1'b0, 0, 16'h0000, 4'b0001, 1'b1, 8'hC1);
        tbl[7]  = mk(OP_LEFT, 1'b0, 8'h00, CC_CC, 1'b1, 1'b0, 0, 16'h0182, 4'b1001, 1'b0, 8'h82);
        tbl[8]  = mk(OP_AND,  1'b0, 8'h0F, CC_MI, 1'b1, 1'b0, 0, 16'h0002, 4'b0000, 1'b0, 8'h02);
        tbl[9]  = mk(OP_XOR,  1'b0, 8'hFF, CC_PL, 1'b1, 1'b0, 0, 16'h00FD, 4'b0001, 1'b0, 8'hFD);
        tbl[10] = mk(OP_OR,   1'b0, 8'h00, CC_PL, 1'b1, 1'b0, 0, 16'h0000, 4'b0001, 1'b1, 8'hFD);
        tbl[11] = mk(OP_OR,   1'b0, 8'h00, CC_VS, 1'b1, 1'b0, 0, 16'h0000, 4'b0001, 1'b1, 8'hFD);
        tbl[12] = mk(OP_OR,   1'b1, 8'h02, CC_AL, 1'b1, 1'b0, 0, 16'h00FF, 4'b0001, 1'b0, 8'hFF);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst/cmd_ready", {31'b0, cmd_ready}, 0);
        chk("rst/outputs", {rsp_valid, rsp_skipped, alu_en, rsp_status, acc, alu_op1, alu_opcode},
            0);
        chk("rst/rsp_result", {16'b0, rsp_result}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst/ready_after_release", {31'b0, cmd_ready}, 1);

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted during ISSUE abandons the command
        cmd_op = OP_ADD; cmd_src = 1'b0; cmd_imm = 8'h11; cmd_cond = CC_AL; cmd_wb = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("rstiss/in_issue", {31'b0, alu_en}, 1);
        rst_n = 1'b0;
        #1;
        chk("rstiss/async", {rsp_valid, cmd_ready, alu_en, acc, alu_op1, rsp_status}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rstiss/ready", {31'b0, cmd_ready}, 1);
        chk("rstiss/no_rsp", {31'b0, rsp_valid}, 0);
        chk("rstiss/acc", {24'b0, acc}, 0);

        // Overflow pair from a cleared state; V status reaches the response
        run_vec(mk(OP_ADD, 1'b0, 8'h7F, CC_AL, 1'b1, 1'b0, 0, 16'h007F, 4'b0000, 1'b0, 8'h7F), "ov1");
        run_vec(mk(OP_ADD, 1'b0, 8'h01, CC_AL, 1'b1, 1'b0, 0, 16'h0080, 4'b0101, 1'b0, 8'h80), "ov2");
        run_vec(mk(OP_ADD, 1'b0, 8'h01, CC_AL, 1'b0, 1'b0, 2, 16'h0081,
                   STICKY ? 4'b0101 : 4'b0001, 1'b0, 8'h80), "stky1");
        run_vec(mk(OP_ADD, 1'b0, 8'hFF, CC_AL, 1'b1, 1'b0, 0, 16'h007F, 4'b1100, 1'b0, 8'h7F), "wrap");

        // flg_clr coincident with the ISSUE capture: clear wins, result/acc still update
        run_vec(mk(OP_ADD, 1'b0, 8'h01, CC_AL, 1'b1, 1'b1, 0, 16'h0080, 4'b0000, 1'b0, 8'h80), "clr");

        // Set V, then a non-overflow ADD, then a standalone flg_clr
        run_vec(mk(OP_ADD, 1'b0, 8'h80, CC_AL, 1'b0, 1'b0, 0, 16'h0000, 4'b1110, 1'b0, 8'h80), "vset");
        run_vec(mk(OP_ADD, 1'b0, 8'h00, CC_AL, 1'b0, 1'b0, 0, 16'h0080,
                   STICKY ? 4'b0101 : 4'b0001, 1'b0, 8'h80), "stky2");
        flg_clr = 1'b1;
        @(posedge clk); #1;
        flg_clr = 1'b0;
        run_vec(mk(OP_ADD, 1'b0, 8'h00, CC_VS, 1'b0, 1'b0, 0, 16'h0000, 4'b0000, 1'b1, 8'h80), "vclr");
        run_vec(mk(OP_ADD, 1'b0, 8'h00, CC_AL, 1'b0, 1'b0, 0, 16'h0080, 4'b0001, 1'b0, 8'h80), "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_flag_ctrl.md
# alu_flag_ctrl

Sequencing front end for the 8-bit flag-producing ALU. It accepts commands over a valid/ready handshake and holds an 8-bit accumulator and a 4-bit status register. For each command it drives the ALU operand/opcode/enable ports, captures the returned result and status, and returns a response over a second valid/ready handshake. Commands can be made conditional on the stored flags, so the block is both the ALU's command source and the consumer of its flags.

## Interface
- No parameters; widths fixed (8-bit operands, 16-bit result, 4-bit status).
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_op  in  4  ALU opcode, ALU encoding
- cmd_src  in  1  0: op1=acc, op2=imm; 1: op1=imm, op2=acc
- cmd_imm  in  8  immediate operand
- cmd_cond  in  3  execute condition on stored status
- cmd_wb  in  1  write result[7:0] into accumulator
- flg_clr  in  1  synchronous pulse, clears status register
- alu_op1, alu_op2  out  8  ALU operands
- alu_opcode  out  4  ALU opcode
- alu_en  out  1  ALU enable
- alu_result  in  16  ALU result (combinational from ALU)
- alu_status  in  4  ALU status {C,V,Z,N}
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_result  out  16  captured result (0 if skipped)
- rsp_status  out  4  status register after the command
- rsp_skipped  out  1  condition false, command not executed
- acc  out  8  accumulator value

## Operation
- States: IDLE, ISSUE, RESP. Reset to IDLE; acc=0, status=0, all outputs 0. cmd_ready=0 while rst_n low.
- IDLE: cmd_ready=1. On accept, the command registers and cmd_cond is evaluated against the current status register.
  - Condition true: go to ISSUE.
  - Condition false: go to RESP with rsp_skipped=1, rsp_result=0; acc and status unchanged.
- Condition codes: 000 AL, 001 EQ (Z), 010 NE (!Z), 011 CS (C), 100 CC (!C), 101 MI (N), 110 PL (!N), 111 VS (V).
- ISSUE, one cycle:
  - alu_en=1; operands and opcode come from the registered command and the current acc.
  - At the closing edge: rsp_result<=alu_result; status<=alu_status; if cmd_wb, acc<=alu_result[7:0]. Then go to RESP.
- RESP: rsp_valid=1, data stable until rsp_valid&&rsp_ready, then go to IDLE. cmd_ready=0 in ISSUE and RESP.
- alu_en=0 and alu operands/opcode=0 outside ISSUE.
- flg_clr clears status in any state. If it coincides with the ISSUE capture, clear wins for status; result and acc still update.
- 16-bit results (NOT, LEFT, RIGHT) are returned whole. Write-back takes the low byte only.

## Timing
- Accept edge T. Executed command: ISSUE in cycle T+1, rsp_valid from T+2. Skipped command: rsp_valid from T+1.
- No overlap: at most one command in flight. Next cmd_ready is the cycle after the response handshake.
- Back-to-back executed throughput: one command per 3 cycles with rsp_ready held high.
- Reset asserted in any state abandons the command with no response. Outputs go to reset values asynchronously.

## Configuration
- ALU_FLAG_CTRL_STICKY_V_EN defined: the status V bit is sticky. Capture ORs alu_status[2] into it, and it clears only by flg_clr or reset. C, Z, N still overwrite.
- Undefined: all four bits overwrite on each executed command.

## Structure
- Package alu_pkg holds:
  - opcode localparams (ADD 0100, SUB 0101, AND 0110, OR 0111, NOT 0000, NAND 0001, NOR 0010, XOR 0011, XNOR 1100, INC 1101, DEC 1110, LEFT 1111, RIGHT 1000, ARTH 1001);
  - status bit indices C=3, V=2, Z=1, N=0;
  - condition code encodings;
  - FSM state encodings.
- One sub-module, alu_cond_eval: combinational, status[3:0] and cond[2:0] in, take out.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- ADD imm 0x7F (src0, AL, wb) then ADD imm 0x01 (wb): second response rsp_result=0x0080, rsp_status=4'b0101, acc=0x80. rsp_valid is 2 cycles after accept.
- From acc=0x00, SUB imm 0x01 (src0, AL): rsp_result=0x00FF, rsp_status=4'b1001, acc unchanged when wb=0.
- With status Z=0, send an EQ command: rsp_skipped=1 one cycle after accept, alu_en never high, acc and status unchanged. Then an NE command executes.
- Hold rsp_ready=0 for 5 cycles: rsp_valid/rsp_result/rsp_status stable and cmd_ready=0 throughout. A new command is accepted the cycle after the handshake.
- Assert rst_n low during ISSUE: no response, acc=0, status=0, cmd_ready=1 the first cycle after release.
- Pulse flg_clr coincident with ISSUE of ADD 0x7F+0x01: status=0, rsp_result=0x0080. With ALU_FLAG_CTRL_STICKY_V_EN, V stays 1 across a following non-overflow ADD until flg_clr.
